// File: rtl/dm_lsu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dm_lsu_mem_pkg
//  Purpose  : Shared definitions for the load/store data memory: access-size
//             encodings, controller state encoding and byte-lane geometry.
//  Revision : 1.0 - initial release
// ============================================================================
package dm_lsu_mem_pkg;

    // Access size / sign encodings carried on the Op field
    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_HU = 3'b010;
    localparam logic [2:0] OP_B  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;

    // Controller states
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Little-endian byte lanes: lane k occupies bits [8k+7:8k]
    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;

endpackage : dm_lsu_mem_pkg
`default_nettype wire

// File: rtl/dm_lsu_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : dm_lsu_mem_if
//  Purpose  : Request/ready bus between the M-stage and the data memory.
//  Signals  : req, mem_wr, op[2:0], addr[31:0], wd[31:0]  (requester -> memory)
//             rd[31:0], ready, err, busy                  (memory -> requester)
//  Modports : master (requester side), slave (memory side)
//  Revision : 1.0 - initial release
// ============================================================================
interface dm_lsu_mem_if;
    logic        req;
    logic        mem_wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, mem_wr, op, addr, wd,
        input  rd, ready, err, busy
    );

    modport slave (
        input  req, mem_wr, op, addr, wd,
        output rd, ready, err, busy
    );
endinterface : dm_lsu_mem_if
`default_nettype wire

// File: rtl/dm_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : dm_lsu_align
//  Purpose  : Purely combinational lane steering for sub-word accesses.
//  Ports    : i_op[2:0]      access size/sign
//             i_addr_lo[1:0] byte offset within the word
//             i_wd[31:0]     right-justified store data
//             i_raw[31:0]    word currently held in memory
//             o_be[3:0]      byte enables for a store
//             o_wdata[31:0]  store data replicated onto its lanes
//             o_rdata[31:0]  extracted and extended load data
//             o_misalign     offset not aligned to size, or Op illegal
//  Revision : 1.0 - initial release
// ============================================================================
module dm_lsu_align
    import dm_lsu_mem_pkg::*;
(
    input  wire logic [2:0]  i_op,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [31:0] i_wd,
    input  wire logic [31:0] i_raw,
    output logic      [3:0]  o_be,
    output logic      [31:0] o_wdata,
    output logic      [31:0] o_rdata,
    output logic             o_misalign
);

    logic [31:0] w_shift;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_shift = i_raw >> {i_addr_lo, 3'b000};
    assign w_byte  = w_shift[LANE_W-1:0];
    assign w_half  = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];

    // Store data is replicated across every lane so the byte enables alone
    // pick the destination; no store-side shifter is needed.
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = 32'h0000_0000;
        o_rdata    = 32'h0000_0000;
        o_misalign = 1'b0;
        case (i_op)
            OP_W: begin
                o_misalign = |i_addr_lo;
                o_be       = 4'b1111;
                o_wdata    = i_wd;
                o_rdata    = i_raw;
            end
            OP_H, OP_HU: begin
                o_misalign = i_addr_lo[0];
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wd[15:0]}};
                o_rdata    = (i_op == OP_H) ? {{16{w_half[15]}}, w_half}
                                            : {16'h0000, w_half};
            end
            OP_B, OP_BU: begin
                o_be       = 4'b0001 << i_addr_lo;
                o_wdata    = {NUM_LANES{i_wd[LANE_W-1:0]}};
                o_rdata    = (i_op == OP_B) ? {{24{w_byte[7]}}, w_byte}
                                            : {24'h000000, w_byte};
            end
            default: o_misalign = 1'b1;
        endcase
    end

endmodule : dm_lsu_align
`default_nettype wire

// File: rtl/dm_lsu_mem.sv
`default_nettype none
// ============================================================================
//  Module   : dm_lsu_mem
//  Purpose  : Byte-addressable data memory with sub-word loads/stores,
//             error reporting, configurable response latency and a
//             post-reset clear sweep.
//  Ports    : clk  rising-edge clock
//             rst  asynchronous active-high reset
//             bus  dm_lsu_mem_if.slave (req/mem_wr/op/addr/wd in,
//                  rd/ready/err/busy out)
//  Revision : 1.0 - initial release
// ============================================================================
module dm_lsu_mem
    import dm_lsu_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          LATENCY        = 0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    dm_lsu_mem_if.slave bus
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  c_WCNT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);
    localparam state_t      c_RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic [31:0]      r_mem [DEPTH_WORDS];
    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_cnt;
    logic [2:0]       r_wcnt;
    logic             r_ready;
    logic [31:0]      r_rd;
    logic             r_err;

    logic [31:0]      w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_oor;
    logic             w_misalign;
    logic             w_err;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_ld;
    logic [31:0]      w_rd_now;
    logic             w_accept;
    logic             w_wr;
    logic             w_ready;
    logic             w_busy;
    logic [31:0]      w_rd_out;
    logic             w_err_out;

    // A borrow on the subtraction or any bit above the index field means the
    // address lies outside the array; out-of-range never aliases.
    assign w_off = bus.addr - BASE_ADDR;
    assign w_idx = w_off[IDX_W+1:2];
    assign w_oor = (bus.addr < BASE_ADDR) | (|w_off[31:IDX_W+2]);

    // BASE_ADDR is word aligned, so the offset's low bits equal the address's.
    dm_lsu_align u_align (
        .i_op       (bus.op),
        .i_addr_lo  (w_off[1:0]),
        .i_wd       (bus.wd),
        .i_raw      (r_mem[w_idx]),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_ld),
        .o_misalign (w_misalign)
    );

    assign w_err    = w_oor | w_misalign;
    assign w_rd_now = w_err ? 32'h0000_0000 : w_ld;
    // r_ready marks the Ready cycle, still busy even though the state is IDLE
    assign w_accept = bus.req & (r_state == ST_IDLE) & ~r_ready;
    assign w_wr     = w_accept & bus.mem_wr & ~w_err;

    // Storage is not reset; the sweep below clears it when enabled.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= 32'h0000_0000;
        end else if (w_wr) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][k*LANE_W +: LANE_W] <= w_wdata[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_RST_STATE;
            r_cnt   <= '0;
            r_wcnt  <= 3'd0;
            r_ready <= 1'b0;
            r_rd    <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (r_state == ST_WAIT) && (r_wcnt == 3'd0);
            if (r_state == ST_CLEAR) begin
                r_cnt <= r_cnt + IDX_W'(1);
            end
            if (w_accept) begin
                r_wcnt <= c_WCNT_INIT;
                r_rd   <= w_rd_now;
                r_err  <= w_err;
            end else if ((r_state == ST_WAIT) && (r_wcnt != 3'd0)) begin
                r_wcnt <= r_wcnt - 3'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLEAR: if (&r_cnt)                      w_next = ST_IDLE;
            ST_IDLE:  if ((LATENCY != 0) && w_accept)  w_next = ST_WAIT;
            ST_WAIT:  if (r_wcnt == 3'd0)              w_next = ST_IDLE;
            default:                                   w_next = ST_IDLE;
        endcase
    end

    // Output logic: zero latency answers combinationally from the live inputs
    always_comb begin
        if (LATENCY == 0) begin
            w_ready   = bus.req & (r_state == ST_IDLE);
            w_rd_out  = w_rd_now;
            w_err_out = w_err;
            w_busy    = (r_state != ST_IDLE);
        end else begin
            w_ready   = r_ready;
            w_rd_out  = r_rd;
            w_err_out = r_err;
            w_busy    = (r_state != ST_IDLE) | r_ready;
        end
    end

    assign bus.ready = w_ready;
    assign bus.rd    = w_rd_out;
    assign bus.err   = w_err_out;
    assign bus.busy  = w_busy;

endmodule : dm_lsu_mem
`default_nettype wire

// File: tb/tb_dm_lsu_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_lsu_mem
//  Purpose  : Directed self-checking bench for dm_lsu_mem. Three instances:
//             u0 DEPTH 16, LATENCY 3, clear on reset
//             u1 DEPTH 16, LATENCY 4, no clear (separate reset)
//             u2 DEPTH 16, LATENCY 0, BASE 0x1000, clear on reset
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dm_lsu_mem;
    import dm_lsu_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        rst1;
    logic [2:0]  r_req;
    logic        r_mem_wr;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wd;

    logic [2:0]  w_ready;
    logic [2:0]  w_err;
    logic [2:0]  w_busy;
    logic [31:0] w_rd [3];

    int total;
    int bad;

    dm_lsu_mem_if bus0 ();
    dm_lsu_mem_if bus1 ();
    dm_lsu_mem_if bus2 ();

    assign bus0.req = r_req[0];
    assign bus1.req = r_req[1];
    assign bus2.req = r_req[2];
    assign bus0.mem_wr = r_mem_wr;  assign bus0.op = r_op;  assign bus0.addr = r_addr;  assign bus0.wd = r_wd;
    assign bus1.mem_wr = r_mem_wr;  assign bus1.op = r_op;  assign bus1.addr = r_addr;  assign bus1.wd = r_wd;
    assign bus2.mem_wr = r_mem_wr;  assign bus2.op = r_op;  assign bus2.addr = r_addr;  assign bus2.wd = r_wd;

    assign w_ready = {bus2.ready, bus1.ready, bus0.ready};
    assign w_err   = {bus2.err,   bus1.err,   bus0.err};
    assign w_busy  = {bus2.busy,  bus1.busy,  bus0.busy};
    assign w_rd[0] = bus0.rd;
    assign w_rd[1] = bus1.rd;
    assign w_rd[2] = bus2.rd;

    dm_lsu_mem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_0000), .LATENCY(3), .CLEAR_ON_RESET(1'b1))
        u0 (.clk(clk), .rst(rst), .bus(bus0));
    dm_lsu_mem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_0000), .LATENCY(4), .CLEAR_ON_RESET(1'b0))
        u1 (.clk(clk), .rst(rst1), .bus(bus1));
    dm_lsu_mem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .LATENCY(0), .CLEAR_ON_RESET(1'b1))
        u2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete access on instance d. n = sampling negedges until Ready
    // (0 for combinational Ready, LATENCY+1 otherwise).
    task automatic do_access(input int d, input logic wr, input logic [2:0] o,
                             input logic [31:0] a, input logic [31:0] data,
                             output logic [31:0] rd, output logic er, output int n);
        @(negedge clk);
        r_mem_wr = wr; r_op = o; r_addr = a; r_wd = data;
        r_req[d] = 1'b1;
        #1;
        n = 0;
        while (!w_ready[d] && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (!w_ready[d]) begin
            total++; bad++;
            $display("FAIL access_timeout dut=%0d addr=%h: ready=%b required=1", d, a, w_ready[d]);
        end
        rd = w_rd[d];
        er = w_err[d];
        @(posedge clk); #1;
        r_req[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst1 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (w_busy[0] !== 1'b1) begin bad++; $display("FAIL reset_busy_u0: got=%b want=1", w_busy[0]); end
        total++; if (w_ready[0] !== 1'b0) begin bad++; $display("FAIL reset_ready_u0: got=%b want=0", w_ready[0]); end
        total++; if (w_err[0] !== 1'b0) begin bad++; $display("FAIL reset_err_u0: got=%b want=0", w_err[0]); end
        total++; if (w_rd[0] !== 32'h0) begin bad++; $display("FAIL reset_rd_u0: got=%h want=0", w_rd[0]); end
        total++; if (w_busy[1] !== 1'b0) begin bad++; $display("FAIL reset_busy_u1: got=%b want=0", w_busy[1]); end
        total++; if (w_busy[2] !== 1'b1) begin bad++; $display("FAIL reset_busy_u2: got=%b want=1", w_busy[2]); end
    endtask

    task automatic test_clear_sweep();
        int cnt;
        logic [31:0] rd;
        logic er;
        int n;
        @(negedge clk);
        rst = 1'b0; rst1 = 1'b0;
        #1;
        cnt = 0;
        while (w_busy[0] && cnt < 100) begin
            cnt++;
            @(negedge clk); #1;
        end
        total++; if (cnt !== 16) begin bad++; $display("FAIL sweep_busy_cycles: got=%0d want=16", cnt); end
        for (int i = 0; i < 16; i++) begin
            do_access(0, 1'b0, OP_W, 32'(i * 4), 32'h0, rd, er, n);
            total++;
            if (rd !== 32'h0 || er !== 1'b0) begin
                bad++; $display("FAIL sweep_zero @%h: rd=%h err=%b want rd=0 err=0", i * 4, rd, er);
            end
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd;
        logic er;
        int n;
        do_access(0, 1'b1, OP_W, 32'h8, 32'h1122_3344, rd, er, n);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL sw_err: got=%b want=0", er); end
        do_access(0, 1'b1, OP_B, 32'h9, 32'h0000_00AB, rd, er, n);
        do_access(0, 1'b1, OP_H, 32'hA, 32'h0000_BEEF, rd, er, n);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL sh_err: got=%b want=0", er); end
        do_access(0, 1'b0, OP_W, 32'h8, 32'h0, rd, er, n);
        total++; if (rd !== 32'hBEEF_AB44) begin bad++; $display("FAIL lw_merge: got=%h want=beefab44", rd); end
        total++; if (n !== 4) begin bad++; $display("FAIL lw_latency: got=%0d want=4", n); end
        do_access(0, 1'b0, OP_B, 32'h9, 32'h0, rd, er, n);
        total++; if (rd !== 32'hFFFF_FFAB) begin bad++; $display("FAIL lb: got=%h want=ffffffab", rd); end
        do_access(0, 1'b0, OP_BU, 32'h9, 32'h0, rd, er, n);
        total++; if (rd !== 32'h0000_00AB) begin bad++; $display("FAIL lbu: got=%h want=000000ab", rd); end
        do_access(0, 1'b0, OP_H, 32'hA, 32'h0, rd, er, n);
        total++; if (rd !== 32'hFFFF_BEEF) begin bad++; $display("FAIL lh: got=%h want=ffffbeef", rd); end
        do_access(0, 1'b0, OP_HU, 32'hA, 32'h0, rd, er, n);
        total++; if (rd !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu: got=%h want=0000beef", rd); end
        do_access(0, 1'b0, OP_BU, 32'h8, 32'h0, rd, er, n);
        total++; if (rd !== 32'h0000_0044) begin bad++; $display("FAIL lbu_lane0: got=%h want=00000044", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er;
        int n;
        do_access(0, 1'b1, OP_W, 32'h4, 32'h0000_0055, rd, er, n);
        do_access(0, 1'b1, OP_W, 32'h6, 32'h0000_0099, rd, er, n);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL sw_misalign_err: got=%b want=1", er); end
        do_access(0, 1'b0, OP_W, 32'h4, 32'h0, rd, er, n);
        total++; if (rd !== 32'h0000_0055) begin bad++; $display("FAIL sw_misalign_nowrite: got=%h want=00000055", rd); end
        do_access(0, 1'b0, OP_H, 32'h3, 32'h0, rd, er, n);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL lh_misalign: err=%b rd=%h want err=1 rd=0", er, rd); end
        do_access(0, 1'b0, OP_W, 32'h40, 32'h0, rd, er, n);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL lw_range: got=%b want=1", er); end
        do_access(0, 1'b0, 3'b111, 32'h0, 32'h0, rd, er, n);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL op_illegal: got=%b want=1", er); end
        do_access(0, 1'b0, OP_HU, 32'h6, 32'h0, rd, er, n);
        total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL lhu_upper_ok: err=%b rd=%h want err=0 rd=0", er, rd); end
    endtask

    task automatic test_latency();
        logic exp_rdy;
        logic exp_busy;
        @(negedge clk);
        r_mem_wr = 1'b0; r_op = OP_W; r_addr = 32'h8; r_wd = 32'h0;
        r_req[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            exp_rdy  = (c == 3);
            exp_busy = (c <= 3);
            total++;
            if (w_ready[0] !== exp_rdy || w_busy[0] !== exp_busy) begin
                bad++;
                $display("FAIL latency_cycle%0d: ready=%b busy=%b want ready=%b busy=%b",
                         c, w_ready[0], w_busy[0], exp_rdy, exp_busy);
            end
            if (c == 3) begin
                total++;
                if (w_rd[0] !== 32'hBEEF_AB44) begin bad++; $display("FAIL latency_rd: got=%h want=beefab44", w_rd[0]); end
            end
            if (w_ready[0]) r_req[0] = 1'b0;
        end
        r_req[0] = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd;
        logic er;
        int n;
        int seen;
        @(negedge clk);
        r_mem_wr = 1'b1; r_op = OP_W; r_addr = 32'h0; r_wd = 32'hDEAD_BEEF;
        r_req[1] = 1'b1;
        @(negedge clk); #1;
        total++; if (w_busy[1] !== 1'b1) begin bad++; $display("FAIL midop_busy: got=%b want=1", w_busy[1]); end
        @(negedge clk);
        rst1 = 1'b1; r_req[1] = 1'b0;
        @(negedge clk);
        rst1 = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (w_ready[1]) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midop_no_ready: ready_cycles=%0d want=0", seen); end
        do_access(1, 1'b0, OP_W, 32'h0, 32'h0, rd, er, n);
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL midop_kept: got=%h want=deadbeef", rd); end
        total++; if (n !== 5) begin bad++; $display("FAIL midop_latency: got=%0d want=5", n); end
    endtask

    task automatic test_lat0();
        logic [31:0] rd;
        logic er;
        int n;
        do_access(2, 1'b0, OP_W, 32'h0000_0FFC, 32'h0, rd, er, n);
        total++; if (er !== 1'b1 || n !== 0) begin bad++; $display("FAIL lat0_below_base: err=%b n=%0d want err=1 n=0", er, n); end
        do_access(2, 1'b1, OP_W, 32'h0000_1000, 32'hCAFE_F00D, rd, er, n);
        total++; if (er !== 1'b0 || n !== 0) begin bad++; $display("FAIL lat0_sw: err=%b n=%0d want err=0 n=0", er, n); end
        do_access(2, 1'b0, OP_W, 32'h0000_1000, 32'h0, rd, er, n);
        total++; if (rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL lat0_lw: got=%h want=cafef00d", rd); end
        do_access(2, 1'b0, OP_W, 32'h0000_1040, 32'h0, rd, er, n);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL lat0_range: got=%b want=1", er); end
        do_access(2, 1'b0, OP_BU, 32'h0000_1003, 32'h0, rd, er, n);
        total++; if (rd !== 32'h0000_00CA) begin bad++; $display("FAIL lat0_lbu: got=%h want=000000ca", rd); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; rst1 = 1'b0;
        r_req = 3'b000; r_mem_wr = 1'b0; r_op = OP_W; r_addr = 32'h0; r_wd = 32'h0;
        #1;
        test_reset();
        test_clear_sweep();
        test_byte_half();
        test_errors();
        test_latency();
        test_reset_mid_op();
        test_lat0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dm_lsu_mem
`default_nettype wire
